timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_TIMERS, default 4: number of timer channels (1..8).
REQ-002 Parameter CNT_W, default 16: counter/reload width in bits (8..16).
REQ-003 Parameter TICK_DIV, default 3: clk_mem cycles per base tick (>=1).
REQ-004 Parameter BASE_ADDR, default 12'h100: byte address of channel 0; channel n at BASE_ADDR+4n.
REQ-005 clk_mem  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 addr  input  24  byte address; only addr[11:0] decoded.
REQ-008 data_in  input  32  write data, right-aligned to the access lane.
REQ-009 data_out  output  32  read data, combinational, right-aligned (word >> 8*addr[1:0]).
REQ-010 read  input  1  read strobe, no side effects.
REQ-011 write  input  1  write strobe, one access per asserted cycle.
REQ-012 width  input  2  00 byte, 01 halfword, 1x word.
REQ-013 irq  output  NUM_TIMERS  per-channel overflow pulse, one clk_mem cycle.

Function
REQ-014 Channel word layout: [CNT_W-1:0] counter (read) / reload (write); [17:16] prescale sel; [18] cascade; [22] irq enable; [23] enable; other bits read 0.
REQ-015 Writes merge data_in into the addressed word via byte mask (width, addr[1:0]); unmasked bytes unchanged.
REQ-016 Writes to counter lanes update only the reload register; the running counter is never written directly.
REQ-017 Reads of counter lanes return the live counter; unmapped addresses read 0.
REQ-018 Base tick: a TICK_DIV-state divider asserts tick one cycle in every TICK_DIV cycles, free-running from reset.
REQ-019 Prescale sel 00/01/10/11 increments the counter every 1/64/256/1024 ticks, using a per-channel 10-bit prescaler.
REQ-020 Channel n>0 with cascade=1 increments only in the cycle channel n-1 overflows, ignoring prescaler; the cascade bit is ignored for channel 0.
REQ-021 Overflow: counter at all-ones and incrementing -> counter loads reload, overflow asserted that cycle, irq[n] pulses next cycle if irq enable=1.
REQ-022 Enable 0->1 by write: counter loads the post-write reload value, prescaler clears, no increment that cycle.
REQ-023 Enable 1->0: counter and prescaler freeze; counter stays readable.
REQ-024 Prescale-sel write while enabled: prescaler clears, counter kept.
REQ-025 Write to a channel's control lane in a tick cycle suppresses that channel's increment for that cycle only.
REQ-026 Reload write coinciding with overflow: overflow loads the pre-write reload value; the new value applies from the next overflow.
REQ-027 A cascade chain ripples within one cycle: n-1 overflow and n increment occur in the same clk_mem edge.
REQ-028 read has no effect on state; read and write in the same cycle: data_out shows pre-write value.

Reset
REQ-029 On rst_n low: all counters, reload, control, prescalers, tick divider and irq cleared to 0 immediately, independent of clk_mem.
REQ-030 Release is synchronous to the next clk_mem edge; the first tick occurs TICK_DIV cycles after release; reset mid-count discards all progress.

Configuration
REQ-031 With TIMER_IRQ_EN defined: irq is generated per REQ-021 and bit 22 is read/write.
REQ-032 Without TIMER_IRQ_EN: irq tied to 0, bit 22 reads 0 and ignores writes; all else unchanged.

Verification
REQ-033 Reload 0xFFFE, enable presc 00 on ch0 -> counter FFFE, FFFF, FFFE at 3-cycle spacing; irq[0] pulse after second increment when bit22=1.
REQ-034 Ch0 presc 01, reload 0 -> counter reaches 1 exactly 192 cycles after enable.
REQ-035 Ch0 reload FFFF presc 00, ch1 cascade reload 0 -> ch1 increments on the same edge as every ch0 overflow (every 3 cycles).
REQ-036 Byte write 0xAB to BASE_ADDR+1 after word write 0x0000_1234 -> reload 0xAB34, control unchanged, counter unaffected.
REQ-037 rst_n low mid-count with ch2 enabled -> all reads return 0, irq=0, before the next clk_mem edge.
REQ-038 Build without TIMER_IRQ_EN, repeat REQ-033 -> irq never asserts, bit 22 reads 0.

Source files
------------

// File: rtl/timer_bank_if.sv
// Register-bus and interrupt bundle between a bus master and timer_bank.
interface timer_bank_if #(
    parameter int NUM_TIMERS = 4
);
    logic [23:0]           addr;
    logic [31:0]           data_in;
    logic [31:0]           data_out;
    logic                  read;
    logic                  write;
    logic [1:0]            width;
    logic [NUM_TIMERS-1:0] irq;

    modport master (output addr, data_in, read, write, width, input  data_out, irq);
    modport slave  (input  addr, data_in, read, write, width, output data_out, irq);
endinterface

// File: rtl/timer_bank.sv
// Bank of up-counting timers (prescale, cascade, reload) behind a byte-lane register bus; reads are combinational.
// Define TIMER_IRQ_EN to build the per-channel overflow interrupt (control bit 22 and irq output).
module timer_bank #(
    parameter int          NUM_TIMERS = 4,
    parameter int          CNT_W      = 16,
    parameter int          TICK_DIV   = 3,
    parameter logic [11:0] BASE_ADDR  = 12'h100
) (
    input  logic        clk_mem,
    input  logic        rst_n,
    timer_bank_if.slave bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CH_W  = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

    logic [DIV_W-1:0]      r_div;
    logic [CNT_W-1:0]      r_cnt    [NUM_TIMERS];
    logic [CNT_W-1:0]      r_reload [NUM_TIMERS];
    logic [9:0]            r_presc  [NUM_TIMERS];
    logic [1:0]            r_sel    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_casc;
    logic [NUM_TIMERS-1:0] r_en;

    logic                  w_tick;
    logic [9:0]            w_word_off;
    logic                  w_hit;
    logic [CH_W-1:0]       w_ch;
    logic [3:0]            w_bmask;
    logic [31:0]           w_mask;
    logic [31:0]           w_wshift;
    logic [31:0]           w_wr_old;
    logic [31:0]           w_wr_new;
    logic [31:0]           w_rd_word;
    logic                  w_wr;
    logic                  w_ctrl_wr;
    logic [NUM_TIMERS-1:0] w_ien;
    logic [NUM_TIMERS-1:0] w_wr_me;
    logic [NUM_TIMERS-1:0] w_pstep;
    logic [NUM_TIMERS-1:0] w_inc;
    logic [NUM_TIMERS-1:0] w_ovf;
    logic                  w_unused;

    function automatic logic [31:0] ctrl_word(input logic [1:0] sel, input logic casc,
                                              input logic ien, input logic en);
        return {8'h00, en, ien, 3'b000, casc, sel, 16'h0000};
    endfunction

    function automatic logic [9:0] presc_last(input logic [1:0] sel);
        case (sel)
            2'b00:   return 10'd0;
            2'b01:   return 10'd63;
            2'b10:   return 10'd255;
            default: return 10'd1023;
        endcase
    endfunction

    assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    assign w_word_off = bus.addr[11:2] - BASE_ADDR[11:2];
    assign w_hit      = (bus.addr[11:2] >= BASE_ADDR[11:2]) && (w_word_off < 10'(NUM_TIMERS));
    assign w_ch       = w_word_off[CH_W-1:0];

    always_comb begin
        case (bus.width)
            2'b00:   w_bmask = 4'b0001 << bus.addr[1:0];
            2'b01:   w_bmask = 4'b0011 << bus.addr[1:0];
            default: w_bmask = 4'b1111;
        endcase
    end

    // Writes see the reload register in the counter lanes; reads see the live counter.
    assign w_mask    = {{8{w_bmask[3]}}, {8{w_bmask[2]}}, {8{w_bmask[1]}}, {8{w_bmask[0]}}};
    assign w_wshift  = bus.data_in << {bus.addr[1:0], 3'b000};
    assign w_wr_old  = ctrl_word(r_sel[w_ch], r_casc[w_ch], w_ien[w_ch], r_en[w_ch]) | 32'(r_reload[w_ch]);
    assign w_wr_new  = (w_wr_old & ~w_mask) | (w_wshift & w_mask);
    assign w_wr      = bus.write && w_hit;
    assign w_ctrl_wr = w_wr && w_bmask[2];
    assign w_rd_word = ctrl_word(r_sel[w_ch], r_casc[w_ch], w_ien[w_ch], r_en[w_ch]) | 32'(r_cnt[w_ch]);
    assign bus.data_out = w_hit ? (w_rd_word >> {bus.addr[1:0], 3'b000}) : 32'h0;

    // Overflow carries ripple from channel 0 upward within the same cycle.
    always_comb begin
        logic carry;
        carry   = 1'b0;
        w_wr_me = '0;
        w_pstep = '0;
        w_inc   = '0;
        w_ovf   = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_wr_me[i] = w_wr && (w_ch == CH_W'(i));
            if (r_en[i] && !(w_ctrl_wr && (w_ch == CH_W'(i)))) begin
                if ((i > 0) && r_casc[i]) begin
                    w_inc[i] = carry;
                end else begin
                    w_pstep[i] = w_tick;
                    w_inc[i]   = w_tick && (r_presc[i] == presc_last(r_sel[i]));
                end
            end
            w_ovf[i] = w_inc[i] && (&r_cnt[i]);
            carry    = w_ovf[i];
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_cnt[i]    <= '0;
                r_reload[i] <= '0;
                r_presc[i]  <= '0;
                r_sel[i]    <= '0;
            end
            r_casc <= '0;
            r_en   <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_wr_me[i] && !r_en[i] && w_wr_new[23]) begin
                    r_cnt[i]   <= w_wr_new[CNT_W-1:0];
                    r_presc[i] <= '0;
                end else begin
                    if (w_ovf[i])      r_cnt[i] <= r_reload[i];
                    else if (w_inc[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
                    if (w_wr_me[i] && w_bmask[2] && r_en[i] && w_wr_new[23])
                        r_presc[i] <= '0;
                    else if (w_pstep[i])
                        r_presc[i] <= w_inc[i] ? 10'd0 : r_presc[i] + 10'd1;
                end
                if (w_wr_me[i]) begin
                    r_reload[i] <= w_wr_new[CNT_W-1:0];
                    r_sel[i]    <= w_wr_new[17:16];
                    r_casc[i]   <= w_wr_new[18];
                    r_en[i]     <= w_wr_new[23];
                end
            end
        end
    end

`ifdef TIMER_IRQ_EN
    logic [NUM_TIMERS-1:0] r_ien;
    logic [NUM_TIMERS-1:0] r_irq;

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            r_ien <= '0;
            r_irq <= '0;
        end else begin
            r_irq <= w_ovf & r_ien;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_wr_me[i]) r_ien[i] <= w_wr_new[22];
            end
        end
    end

    assign w_ien   = r_ien;
    assign bus.irq = r_irq;
`else
    assign w_ien   = '0;
    assign bus.irq = '0;
`endif

    assign w_unused = ^{bus.read, bus.addr[23:12], w_wr_new};
endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed bench for timer_bank against a cycle-level behavioural model.
module tb_timer_bank;
    localparam int          N    = 4;
    localparam int          CW   = 16;
    localparam int          TD   = 3;
    localparam logic [11:0] BASE = 12'h100;
    localparam int          MAXC = (1 << CW) - 1;
`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk_mem = 1'b0;
    logic rst_n   = 1'b1;
    timer_bank_if #(.NUM_TIMERS(N)) bus ();

    timer_bank #(.NUM_TIMERS(N), .CNT_W(CW), .TICK_DIV(TD), .BASE_ADDR(BASE)) dut (
        .clk_mem (clk_mem),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_mem = ~clk_mem;

    int n_checks = 0;
    int n_errors = 0;

    int         m_cnt  [N];
    int         m_rel  [N];
    int         m_sel  [N];
    int         m_casc [N];
    int         m_ien  [N];
    int         m_en   [N];
    int         m_pre  [N];
    int         m_cyc;
    logic [N-1:0] m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int period(input int sel);
        case (sel)
            0:       return 1;
            1:       return 64;
            2:       return 256;
            default: return 1024;
        endcase
    endfunction

    function automatic logic [31:0] model_ctrl(input int ch);
        return (32'(m_en[ch]) << 23) | (32'(m_ien[ch]) << 22) | (32'(m_casc[ch]) << 18) | (32'(m_sel[ch]) << 16);
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a);
        int a12, ch;
        logic [31:0] word;
        a12 = int'(a[11:0]);
        if (a12 < int'(BASE) || a12 >= int'(BASE) + 4 * N) return 32'h0;
        ch   = (a12 - int'(BASE)) / 4;
        word = model_ctrl(ch) | 32'(m_cnt[ch]);
        return word >> (8 * (a12 % 4));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_sel[i] = 0; m_casc[i] = 0;
            m_ien[i] = 0; m_en[i] = 0;  m_pre[i] = 0;
        end
        m_cyc = 0;
        m_irq = '0;
    endtask

    // One clock edge of the timer bank as seen from the register map.
    task automatic model_step(input logic w, input logic [23:0] a, input logic [31:0] d, input logic [1:0] wd);
        int a12, ch, lane, bm;
        logic [31:0] m, oldw, neww;
        logic hit, ctrl_wr, tick, prev_ovf, inc, ovf;
        a12  = int'(a[11:0]);
        hit  = w && (a12 >= int'(BASE)) && (a12 < int'(BASE) + 4 * N);
        ch   = hit ? (a12 - int'(BASE)) / 4 : -1;
        lane = a12 % 4;
        bm   = (wd == 2'd0) ? (1 << lane) : (wd == 2'd1) ? (3 << lane) : 15;
        bm   = bm & 15;
        m    = 32'h0;
        for (int k = 0; k < 4; k++) if ((bm >> k) & 1) m = m | (32'hFF << (8 * k));
        ctrl_wr = hit && (((bm >> 2) & 1) == 1);
        tick    = (m_cyc % TD) == TD - 1;
        m_cyc++;
        prev_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc = 1'b0;
            if (m_en[i] != 0 && !(ctrl_wr && ch == i)) begin
                if (i > 0 && m_casc[i] != 0) begin
                    inc = prev_ovf;
                end else if (tick) begin
                    m_pre[i]++;
                    if (m_pre[i] == period(m_sel[i])) begin
                        m_pre[i] = 0;
                        inc = 1'b1;
                    end
                end
            end
            ovf      = inc && (m_cnt[i] == MAXC);
            m_irq[i] = ovf && (m_ien[i] != 0);
            if (ovf)      m_cnt[i] = m_rel[i];
            else if (inc) m_cnt[i] = m_cnt[i] + 1;
            prev_ovf = ovf;
        end
        if (hit) begin
            oldw = model_ctrl(ch) | 32'(m_rel[ch]);
            neww = (oldw & ~m) | ((d << (8 * lane)) & m);
            if (m_en[ch] == 0 && neww[23]) begin
                m_cnt[ch] = int'(neww[CW-1:0]);
                m_pre[ch] = 0;
            end else if (m_en[ch] != 0 && neww[23] && ctrl_wr) begin
                m_pre[ch] = 0;
            end
            m_rel[ch]  = int'(neww[CW-1:0]);
            m_sel[ch]  = int'(neww[17:16]);
            m_casc[ch] = int'(neww[18]);
            m_en[ch]   = int'(neww[23]);
            if (IRQ_ON) m_ien[ch] = int'(neww[22]);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [23:0] a, input logic [31:0] d, input logic [1:0] wd);
        bus.write = w; bus.read = r; bus.addr = a; bus.data_in = d; bus.width = wd;
        @(negedge clk_mem);
        if (r) check("rd", bus.data_out, model_read(a));
        check("irq", 32'(bus.irq), 32'(m_irq));
        @(posedge clk_mem);
        model_step(w, a, d, wd);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [1:0] wd);
        cyc(1'b1, 1'b0, a, d, wd);
    endtask

    task automatic rd(input logic [23:0] a);
        cyc(1'b0, 1'b1, a, 32'h0, 2'b10);
    endtask

    task automatic expect_rd(input string tag, input logic [23:0] a, input logic [31:0] exp);
        bus.write = 1'b0; bus.read = 1'b1; bus.addr = a; bus.width = 2'b10;
        #1;
        check(tag, bus.data_out, exp);
        cyc(1'b0, 1'b1, a, 32'h0, 2'b10);
    endtask

    task automatic align_tick();
        for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) cyc(1'b0, 1'b0, 24'h0, 32'h0, 2'b10);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.write = 1'b0; bus.read = 1'b1; bus.width = 2'b10;
        for (int i = 0; i < N; i++) begin
            bus.addr = 24'(BASE) + 24'(4 * i);
            #1;
            check(tag, bus.data_out, 32'h0);
        end
        check(tag, 32'(bus.irq), 32'h0);
        model_reset();
        @(posedge clk_mem);
        #1;
        rst_n = 1'b1;
    endtask

    logic        irq_seen;
    int          ch, lane, op;
    logic [1:0]  wd;
    logic [23:0] a;
    logic [31:0] d;

    initial begin
        bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.data_in = '0; bus.width = 2'b10;
        model_reset();
        @(posedge clk_mem);
        #1;
        do_reset("reset_init");

        // Channel 0 near the top of its range, prescale 00, irq enable requested.
        wr(24'(BASE), 32'h0000_FFFE, 2'b10);
        align_tick();
        wr(24'(BASE) + 24'd2, 32'h0000_00C0, 2'b00);
        for (int i = 0; i < 3; i++) expect_rd("ch0_fffe", 24'(BASE), 32'h0080_FFFE | (32'(IRQ_ON) << 22));
        for (int i = 0; i < 3; i++) expect_rd("ch0_ffff", 24'(BASE), 32'h0080_FFFF | (32'(IRQ_ON) << 22));
        check("ch0_irq_pulse", 32'(bus.irq[0]), 32'(IRQ_ON));
        expect_rd("ch0_reload", 24'(BASE), 32'h0080_FFFE | (32'(IRQ_ON) << 22));
        check("ch0_irq_end", 32'(bus.irq[0]), 32'h0);
        irq_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rd(24'(BASE));
            irq_seen = irq_seen | bus.irq[0];
        end
        check("ch0_irq_seen", 32'(irq_seen), 32'(IRQ_ON));
        wr(24'(BASE) + 24'd2, 32'h0, 2'b00);
        for (int i = 0; i < 6; i++) rd(24'(BASE));

        // Byte merge into the reload register of channel 1.
        wr(24'(BASE) + 24'd4, 32'h0000_1234, 2'b10);
        wr(24'(BASE) + 24'd5, 32'h0000_00AB, 2'b00);
        expect_rd("ch1_cnt_untouched", 24'(BASE) + 24'd4, 32'h0000_0000);
        wr(24'(BASE) + 24'd6, 32'h0000_0083, 2'b00);
        expect_rd("ch1_reload_ab34", 24'(BASE) + 24'd4, 32'h0083_AB34);
        wr(24'(BASE) + 24'd6, 32'h0, 2'b00);

        // Prescale 01 from reload 0: first increment 192 cycles after enable.
        wr(24'(BASE), 32'h0000_0000, 2'b10);
        align_tick();
        wr(24'(BASE) + 24'd2, 32'h0000_0081, 2'b00);
        for (int i = 0; i < 191; i++) rd(24'(BASE));
        expect_rd("ch0_presc64_191", 24'(BASE), 32'h0081_0000);
        expect_rd("ch0_presc64_192", 24'(BASE), 32'h0081_0001);
        wr(24'(BASE) + 24'd2, 32'h0, 2'b00);

        // Cascade: ch1 counts every ch0 overflow on the same edge.
        wr(24'(BASE) + 24'd4, 32'h0084_0000, 2'b10);
        wr(24'(BASE), 32'h0080_FFFF, 2'b10);
        for (int i = 0; i < 16; i++) begin
            rd(24'(BASE) + 24'd4);
            rd(24'(BASE));
        end

        // Reload rewritten in an overflow cycle: old reload is loaded, new one next time.
        align_tick();
        wr(24'(BASE), 32'h0000_1000, 2'b01);
        expect_rd("ovf_old_reload", 24'(BASE), 32'h0080_FFFF);
        rd(24'(BASE));
        rd(24'(BASE));
        expect_rd("ovf_new_reload", 24'(BASE), 32'h0080_1000);
        wr(24'(BASE) + 24'd2, 32'h0, 2'b00);
        wr(24'(BASE) + 24'd6, 32'h0, 2'b00);

        // Reset in the middle of counting on channel 2.
        wr(24'(BASE) + 24'd8, 32'h0080_FF00, 2'b10);
        for (int i = 0; i < 5; i++) rd(24'(BASE) + 24'd8);
        do_reset("reset_mid");
        for (int i = 0; i < 4; i++) rd(24'(BASE) + 24'd8);

        for (int k = 0; k < 3000; k++) begin
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, N);
            wd = 2'($urandom_range(0, 3));
            lane = (wd == 2'd0) ? $urandom_range(0, 3) : (wd == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
            a = 24'($urandom);
            a[11:0] = BASE + 12'(4 * ch + lane);
            if ($urandom_range(0, 9) == 0) a[11:0] = 12'($urandom);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[15:4] = 12'hFFF;
            if ($urandom_range(0, 3) != 0) d[17:16] = 2'b00;
            if (wd == 2'd0 && lane == 2 && $urandom_range(0, 3) != 0) d[1:0] = 2'b00;
            if ($urandom_range(0, 999) == 0)
                do_reset("reset_rand");
            else if (op < 4)
                cyc(1'b1, 1'($urandom_range(0, 1)), a, d, wd);
            else if (op < 8)
                cyc(1'b0, 1'b1, a, 32'h0, wd);
            else
                cyc(1'b0, 1'b0, a, 32'h0, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
